// File: rtl/libtech.sv
// Shared technology package: DRAM reset sequencer state and status types.
// Imported by dram_rst_seq and by any block that consumes its status.
package libtech;

    // Bring-up sequencer states
    typedef enum logic [2:0] {
        WAIT_LOCK,
        HOLD,
        CAL,
        RUN,
        FAIL
    } dram_rst_state_type;

    // Widest retry counter that a status consumer has to carry
    localparam int DRAM_RST_RETRY_W = 8;

    // Status bundle exported to the rest of the system
    typedef struct packed {
        logic                        ready;
        logic                        fail;
        logic [DRAM_RST_RETRY_W-1:0] retry_cnt;
    } dram_rst_status_type;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop single-bit synchronizer with synchronous reset to 0.
// Ports: clk_i clock, rst_i sync reset, d_i async input, q_o synced output.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/dram_rst_seq.sv
// DRAM clock-generator reset / bring-up sequencer with timeout and retries.
// Ports: clk, rst (sync, high), pll_locked/cal_done/cal_err (async),
//        soft_req (clk domain); dramrst, ready, fail, retry_cnt (registered).
module dram_rst_seq
    import libtech::*;
#(
    parameter int RST_CYCLES  = 64,
    parameter int CAL_TIMEOUT = 1048576,
    parameter int MAX_RETRY   = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             pll_locked,
    input  logic                             cal_done,
    input  logic                             cal_err,
    input  logic                             soft_req,
    output logic                             dramrst,
    output logic                             ready,
    output logic                             fail,
    output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt
);

    localparam int HW = $clog2(RST_CYCLES);
    localparam int TW = $clog2(CAL_TIMEOUT);
    localparam int RW = $clog2(MAX_RETRY + 1);

    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(CAL_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    logic lock_s;
    logic done_s;
    logic err_s;

    dram_rst_state_type state_q, state_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic [RW-1:0]      retry_q, retry_d;
    logic               dramrst_q, dramrst_d;
    logic               ready_q, ready_d;
    logic               fail_q, fail_d;

    bit_sync #(.STAGES(SYNC_STAGES)) u_sync_lock (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (pll_locked),
        .q_o   (lock_s)
    );

    bit_sync #(.STAGES(SYNC_STAGES)) u_sync_done (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (cal_done),
        .q_o   (done_s)
    );

    bit_sync #(.STAGES(SYNC_STAGES)) u_sync_err (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (cal_err),
        .q_o   (err_s)
    );

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= WAIT_LOCK;
            hold_q    <= '0;
            tmo_q     <= '0;
            retry_q   <= '0;
            dramrst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            tmo_q     <= tmo_d;
            retry_q   <= retry_d;
            dramrst_q <= dramrst_d;
            ready_q   <= ready_d;
            fail_q    <= fail_d;
        end
    end

    // Next state, retry bookkeeping and counters
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        unique case (state_q)
            WAIT_LOCK: begin
                if (lock_s) state_d = HOLD;
            end
            HOLD: begin
                // done_s must be low so a stale done cannot skip CAL
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (hold_q == HOLD_LAST && !done_s) begin
                    state_d = CAL;
                end
            end
            CAL: begin
                // err beats done, done beats the timeout
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (err_s || (!done_s && tmo_q == TMO_LAST)) begin
                    if (retry_q == RETRY_MAX) begin
                        state_d = FAIL;
                    end else begin
                        state_d = HOLD;
                        retry_d = retry_q + RW'(1);
                    end
                end else if (done_s) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (!done_s) begin
                    state_d = HOLD;
                end else if (soft_req) begin
                    state_d = HOLD;
                    retry_d = '0;
                end
            end
            FAIL: begin
                if (soft_req) begin
                    state_d = WAIT_LOCK;
                    retry_d = '0;
                end
            end
            default: state_d = WAIT_LOCK;
        endcase

        // A soft request outside RUN/FAIL only restarts the retry budget
        if (soft_req && state_q inside {WAIT_LOCK, HOLD, CAL}) begin
            retry_d = '0;
        end

        // Counters restart on each entry and saturate at their last value
        hold_d = '0;
        if (state_q == HOLD && state_d == HOLD) begin
            hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + HW'(1);
        end
        tmo_d = '0;
        if (state_q == CAL && state_d == CAL) begin
            tmo_d = (tmo_q == TMO_LAST) ? tmo_q : tmo_q + TW'(1);
        end
    end

    // Output decode from next state so all outputs move together
    always_comb begin
        dramrst_d = 1'b1;
        ready_d   = 1'b0;
        fail_d    = 1'b0;
        unique case (state_d)
            WAIT_LOCK: dramrst_d = 1'b1;
            HOLD:      dramrst_d = 1'b1;
            CAL:       dramrst_d = 1'b0;
            RUN: begin
                dramrst_d = 1'b0;
                ready_d   = 1'b1;
            end
            FAIL: begin
                dramrst_d = 1'b1;
                fail_d    = 1'b1;
            end
            default: dramrst_d = 1'b1;
        endcase
    end

    assign dramrst   = dramrst_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_dram_rst_seq.sv
// Scoreboard bench for dram_rst_seq: expected output tuples are queued
// with their due cycle when stimulus is applied and compared on arrival.
module tb_dram_rst_seq;

    logic       clk;
    logic       rst;
    logic       pll_locked;
    logic       cal_done;
    logic       cal_err;
    logic       soft_req;
    logic       dramrst;
    logic       ready;
    logic       fail;
    logic [1:0] retry_cnt;

    dram_rst_seq #(
        .RST_CYCLES  (16),
        .CAL_TIMEOUT (32),
        .MAX_RETRY   (2),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .cal_done   (cal_done),
        .cal_err    (cal_err),
        .soft_req   (soft_req),
        .dramrst    (dramrst),
        .ready      (ready),
        .fail       (fail),
        .retry_cnt  (retry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int    at;
        string tag;
        int    val;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input int got, input int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, want, cyc);
    endtask

    // {dramrst, ready, fail, retry_cnt[1:0]}
    function automatic int pack(input bit d, input bit r, input bit f,
                                input int rc);
        return (int'(d) << 4) | (int'(r) << 3) | (int'(f) << 2) | (rc & 3);
    endfunction

    task automatic expect_at(input int at, input string tag, input bit d,
                             input bit r, input bit f, input int rc);
        exp_t e;
        int   i;
        e.at  = at;
        e.tag = tag;
        e.val = pack(d, r, f, rc);
        i = 0;
        while (i < sb.size() && sb[i].at <= at) i++;
        sb.insert(i, e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        chk("excl", int'(dramrst & ready), 0);
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            chk(e.tag, pack(dramrst, ready, fail, int'(retry_cnt)), e.val);
        end
    endtask

    task automatic run_until(input int t);
        while (cyc < t) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int h;
        int q;
        exp_t e;
        rst        = 1'b1;
        pll_locked = 1'b0;
        cal_done   = 1'b0;
        cal_err    = 1'b0;
        soft_req   = 1'b0;
        repeat (3) tick();
        expect_at(cyc + 1, "reset", 1, 0, 0, 0);
        tick();
        rst = 1'b0;
        tick();

        // Normal bring-up
        h = cyc;
        pll_locked = 1'b1;
        expect_at(h + 18, "t1_hold", 1, 0, 0, 0);
        expect_at(h + 19, "t1_fall", 0, 0, 0, 0);
        run_until(h + 39);
        cal_done = 1'b1;
        expect_at(h + 41, "t1_pre", 0, 0, 0, 0);
        expect_at(h + 42, "t1_rdy", 0, 1, 0, 0);
        run_until(h + 49);

        // Lock loss in RUN (controller drops done with it)
        h = cyc;
        pll_locked = 1'b0;
        cal_done   = 1'b0;
        expect_at(h + 2, "t4_still", 0, 1, 0, 0);
        expect_at(h + 3, "t4_drop", 1, 0, 0, 0);
        run_until(h + 5);
        pll_locked = 1'b1;
        expect_at(h + 23, "t4_hold", 1, 0, 0, 0);
        expect_at(h + 24, "t4_fall", 0, 0, 0, 0);
        run_until(h + 25);

        // Error beats done in the same cycle
        h = cyc;
        cal_err  = 1'b1;
        cal_done = 1'b1;
        expect_at(h + 2, "t3_cal", 0, 0, 0, 0);
        expect_at(h + 3, "t3_retry", 1, 0, 0, 1);
        expect_at(h + 4, "t3_nordy", 1, 0, 0, 1);
        tick();
        cal_err  = 1'b0;
        cal_done = 1'b0;

        // Soft request in HOLD clears retries, then time out to FAIL
        h = h + 3;
        run_until(h + 1);
        soft_req = 1'b1;
        expect_at(h + 2, "t2_clr", 1, 0, 0, 0);
        tick();
        soft_req = 1'b0;
        expect_at(h + 15,  "t2_h0",  1, 0, 0, 0);
        expect_at(h + 16,  "t2_c1",  0, 0, 0, 0);
        expect_at(h + 47,  "t2_c1e", 0, 0, 0, 0);
        expect_at(h + 48,  "t2_r1",  1, 0, 0, 1);
        expect_at(h + 63,  "t2_h1",  1, 0, 0, 1);
        expect_at(h + 64,  "t2_c2",  0, 0, 0, 1);
        expect_at(h + 95,  "t2_c2e", 0, 0, 0, 1);
        expect_at(h + 96,  "t2_r2",  1, 0, 0, 2);
        expect_at(h + 111, "t2_h2",  1, 0, 0, 2);
        expect_at(h + 112, "t2_c3",  0, 0, 0, 2);
        expect_at(h + 143, "t2_c3e", 0, 0, 0, 2);
        expect_at(h + 144, "t2_fail", 1, 0, 1, 2);
        expect_at(h + 190, "t2_stay", 1, 0, 1, 2);
        run_until(h + 190);
        soft_req = 1'b1;
        expect_at(h + 191, "t2_rec", 1, 0, 0, 0);
        tick();
        soft_req = 1'b0;
        expect_at(h + 207, "t2_h3",  1, 0, 0, 0);
        expect_at(h + 208, "t2_c4",  0, 0, 0, 0);
        expect_at(h + 240, "t2_r4",  1, 0, 0, 1);
        expect_at(h + 256, "t2_c5",  0, 0, 0, 1);
        run_until(h + 260);

        // Reset mid-CAL
        rst = 1'b1;
        expect_at(h + 261, "t6_rst", 1, 0, 0, 0);
        tick();
        rst = 1'b0;
        expect_at(h + 279, "t6_hold", 1, 0, 0, 0);
        expect_at(h + 280, "t6_fall", 0, 0, 0, 0);
        run_until(h + 280);
        cal_done = 1'b1;
        expect_at(h + 282, "t6_pre", 0, 0, 0, 0);
        expect_at(h + 283, "t6_rdy", 0, 1, 0, 0);
        run_until(h + 290);

        // Stale done holds dramrst past the hold time
        q = cyc;
        pll_locked = 1'b0;
        expect_at(q + 3, "t5_drop", 1, 0, 0, 0);
        run_until(q + 5);
        pll_locked = 1'b1;
        expect_at(q + 24, "t5_stale", 1, 0, 0, 0);
        expect_at(q + 40, "t5_stale2", 1, 0, 0, 0);
        run_until(q + 40);
        cal_done = 1'b0;
        expect_at(q + 42, "t5_hold", 1, 0, 0, 0);
        expect_at(q + 43, "t5_fall", 0, 0, 0, 0);
        run_until(q + 50);

        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk({"late_", e.tag}, -1, e.val);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
